spi_sclk_gen: RTL
=================

SPI_SCLK_GEN -- requirements
Module: spi_sclk_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 8, width of divisor field.
REQ-002 SHALL have parameter BITS_W, default 6, width of bit-count field.
REQ-003 SHALL have parameter RST_DIV, default 4, divisor loaded at reset.
REQ-004 SHALL have port i_clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_cfg_valid  input  1  config write strobe.
REQ-007 SHALL have port i_cfg_div  input  DIV_W  SCLK period in i_clk cycles.
REQ-008 SHALL have port i_cfg_bits  input  BITS_W  SCLK cycles per burst.
REQ-009 SHALL have port i_cfg_cpol  input  1  SCLK idle level.
REQ-010 SHALL have port i_cfg_cpha  input  1  SPI phase mode.
REQ-011 SHALL have port i_start  input  1  burst request, sampled only when o_ready=1.
REQ-012 SHALL have port i_abort  input  1  terminate burst in progress.
REQ-013 SHALL have port o_ready  output  1  idle, accepts config/start.
REQ-014 SHALL have port o_sclk  output  1  generated serial clock, registered.
REQ-015 SHALL have port o_sample  output  1  one-cycle strobe, edge where receiver samples.
REQ-016 SHALL have port o_shift  output  1  one-cycle strobe, edge where transmitter shifts.
REQ-017 SHALL have port o_done  output  1  one-cycle strobe, burst completed normally.
REQ-018 SHALL have port o_cfg_err  output  1  one-cycle strobe, config write rejected.

Function
REQ-019 SHALL implement states IDLE, RUN, TAIL; o_ready=1 only in IDLE.
REQ-020 SHALL accept config only in IDLE with i_cfg_valid=1 and i_cfg_div even, i_cfg_div>=2, i_cfg_bits!=0; accepted values take effect next cycle.
REQ-021 SHALL reject a config write (odd div, div<2, bits=0, or not IDLE): stored config unchanged, o_cfg_err=1 the following cycle.
REQ-022 SHALL, when i_cfg_valid and i_start coincide in IDLE, apply the new config first; rejected config leaves start proceeding with old config.
REQ-023 SHALL hold o_sclk=stored CPOL in IDLE, updating the cycle after an accepted CPOL change.
REQ-024 SHALL, on i_start=1 in IDLE at cycle 0, enter RUN; o_ready=0 from cycle 1.
REQ-025 SHALL, with H=div/2 and N=bits, toggle o_sclk at cycles H, 2H, ..., 2N*H; odd-numbered toggles are leading edges, even-numbered toggles trailing edges.
REQ-026 SHALL, for CPHA=0, pulse o_sample with each leading edge and o_shift with each trailing edge except the last.
REQ-027 SHALL, for CPHA=1, pulse o_shift with each leading edge and o_sample with each trailing edge.
REQ-028 SHALL assert o_sample/o_shift in the same cycle o_sclk takes its new value; never both in one cycle.
REQ-029 SHALL enter TAIL after edge 2N, hold o_sclk=CPOL for H cycles, pulse o_done at cycle (2N+1)*H, and be IDLE with o_ready=1 at cycle (2N+1)*H+1.
REQ-030 SHALL ignore i_start outside IDLE; i_start held high in IDLE starts a new burst back-to-back.
REQ-031 SHALL, on i_abort in RUN or TAIL, return to IDLE next cycle: o_sclk=CPOL, o_ready=1, no o_done, no further strobes; i_abort in IDLE ignored.
REQ-032 SHALL use internal half-period counter DIV_W-1 bits and edge counter BITS_W+1 bits; no wrap at max values (div=2^DIV_W-2, bits=2^BITS_W-1).

Reset
REQ-033 SHALL, on i_rst=1 at any clock edge including mid-burst, enter IDLE with div=RST_DIV, bits=8, CPOL=0, CPHA=0.
REQ-034 SHALL drive during and after reset: o_ready=1, o_sclk=0, o_sample=o_shift=o_done=o_cfg_err=0.
REQ-035 SHALL ignore i_start, i_cfg_valid, i_abort while i_rst=1.

Verification
REQ-036 SHALL test reset: hold i_rst 16 cycles mid-burst, release -> o_ready=1, o_sclk=0 next cycle, no strobes.
REQ-037 SHALL test div=250,100,4,2 with bits=8, CPOL=0, CPHA=0 -> 8 SCLK periods, 8 o_sample, 7 o_shift, o_done at cycle 17*div/2, o_ready at cycle 17*div/2+1.
REQ-038 SHALL test all four CPOL/CPHA modes, div=4, bits=3 -> idle level =CPOL, strobe edges per REQ-026/027.
REQ-039 SHALL test config errors: div=3, div=0, bits=0, write during RUN -> o_cfg_err pulse, burst timing unchanged.
REQ-040 SHALL test i_abort at cycle 5 of div=4 burst -> o_ready=1, o_sclk=CPOL at cycle 6, no o_done.
REQ-041 SHALL test i_start held high, div=2, bits=1 -> bursts back-to-back, o_ready high exactly one cycle between.

Source files
------------

// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: programmable divisor, burst length and CPOL/CPHA, with sample/shift strobes.
// Latency: first SCLK edge div/2 cycles after start; o_done at (2*bits+1)*div/2; o_ready the cycle after.
// Backpressure: start and config are accepted only while o_ready=1; config writes outside IDLE are rejected.
module spi_sclk_gen #(
   parameter int DIV_W   = 8,
   parameter int BITS_W  = 6,
   parameter int RST_DIV = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_cfg_valid,
   input  logic [DIV_W-1:0]  i_cfg_div,
   input  logic [BITS_W-1:0] i_cfg_bits,
   input  logic              i_cfg_cpol,
   input  logic              i_cfg_cpha,
   input  logic              i_start,
   input  logic              i_abort,
   output logic              o_ready,
   output logic              o_sclk,
   output logic              o_sample,
   output logic              o_shift,
   output logic              o_done,
   output logic              o_cfg_err
);

   typedef enum logic [1:0] {IDLE, RUN, TAIL} state_t;

   localparam logic [DIV_W-2:0] H_ONE = (DIV_W-1)'(1);
   localparam logic [BITS_W:0]  E_ONE = (BITS_W+1)'(1);

   state_t              state, state_n;
   logic [DIV_W-1:0]    div_q, div_n;
   logic [BITS_W-1:0]   bits_q, bits_n;
   logic                cpol_q, cpol_n;
   logic                cpha_q, cpha_n;
   logic [DIV_W-2:0]    hcnt, hcnt_n;
   logic [BITS_W:0]     ecnt, ecnt_n;
   logic                sclk_n, sample_n, shift_n, done_n, cfg_err_n;

   logic                cfg_ok;
   logic [DIV_W-1:0]    eff_div;
   logic [BITS_W-1:0]   eff_bits;
   logic                eff_cpol, eff_cpha;
   logic [DIV_W-2:0]    half_m1;
   logic [BITS_W:0]     last_edge;
   logic [BITS_W:0]     ecnt_inc;

   // A write is legal only when idle, even, at least 2, and with a nonzero burst length.
   assign cfg_ok = i_cfg_valid && (state == IDLE) && !i_cfg_div[0]
                   && (|i_cfg_div[DIV_W-1:1]) && (|i_cfg_bits);

   // Accepted config is visible to a start in the same cycle; otherwise the stored copy is used.
   assign eff_div   = cfg_ok ? i_cfg_div  : div_q;
   assign eff_bits  = cfg_ok ? i_cfg_bits : bits_q;
   assign eff_cpol  = cfg_ok ? i_cfg_cpol : cpol_q;
   assign eff_cpha  = cfg_ok ? i_cfg_cpha : cpha_q;
   assign half_m1   = eff_div[DIV_W-1:1] - H_ONE;
   assign last_edge = {eff_bits, 1'b0};
   assign ecnt_inc  = ecnt + E_ONE;
   assign o_ready   = (state == IDLE);

   // Next-state and registered-output logic for the IDLE/RUN/TAIL sequencer.
   always_comb begin
      state_n   = state;
      hcnt_n    = hcnt;
      ecnt_n    = ecnt;
      sclk_n    = o_sclk;
      sample_n  = 1'b0;
      shift_n   = 1'b0;
      done_n    = 1'b0;
      cfg_err_n = i_cfg_valid && !cfg_ok;
      div_n     = eff_div;
      bits_n    = eff_bits;
      cpol_n    = eff_cpol;
      cpha_n    = eff_cpha;
      case (state)
         IDLE: begin
            sclk_n = eff_cpol;
            hcnt_n = '0;
            ecnt_n = '0;
            if (i_start) begin
               state_n = RUN;
               // The start cycle is position 0 of the first half period, so div=2 toggles at once.
               if (half_m1 == '0) begin
                  sclk_n   = ~eff_cpol;
                  ecnt_n   = E_ONE;
                  sample_n = ~eff_cpha;
                  shift_n  = eff_cpha;
               end else begin
                  hcnt_n = H_ONE;
               end
            end
         end
         RUN: begin
            if (i_abort) begin
               state_n = IDLE;
               sclk_n  = cpol_q;
               hcnt_n  = '0;
               ecnt_n  = '0;
            end else if (hcnt == half_m1) begin
               hcnt_n = '0;
               ecnt_n = ecnt_inc;
               sclk_n = ~o_sclk;
               if (ecnt_inc[0]) begin
                  // Odd edge count: leading edge.
                  sample_n = ~cpha_q;
                  shift_n  = cpha_q;
               end else begin
                  // Even edge count: trailing edge; mode 0 has nothing left to shift after the last one.
                  sample_n = cpha_q;
                  shift_n  = ~cpha_q && (ecnt_inc != last_edge);
               end
               if (ecnt_inc == last_edge) state_n = TAIL;
            end else begin
               hcnt_n = hcnt + H_ONE;
            end
         end
         TAIL: begin
            if (i_abort || o_done) begin
               state_n = IDLE;
               sclk_n  = cpol_q;
               hcnt_n  = '0;
               ecnt_n  = '0;
            end else if (hcnt == half_m1) begin
               done_n = 1'b1;
               hcnt_n = '0;
            end else begin
               hcnt_n = hcnt + H_ONE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State, config and output registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= IDLE;
         div_q     <= DIV_W'(RST_DIV);
         bits_q    <= BITS_W'(8);
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
         hcnt      <= '0;
         ecnt      <= '0;
         o_sclk    <= 1'b0;
         o_sample  <= 1'b0;
         o_shift   <= 1'b0;
         o_done    <= 1'b0;
         o_cfg_err <= 1'b0;
      end else begin
         state     <= state_n;
         div_q     <= div_n;
         bits_q    <= bits_n;
         cpol_q    <= cpol_n;
         cpha_q    <= cpha_n;
         hcnt      <= hcnt_n;
         ecnt      <= ecnt_n;
         o_sclk    <= sclk_n;
         o_sample  <= sample_n;
         o_shift   <= shift_n;
         o_done    <= done_n;
         o_cfg_err <= cfg_err_n;
      end
   end

endmodule
